// File: rtl/paddle_ai_ctl.sv
// Computer-controlled paddle: tracks the ball's y when it is near, otherwise returns home.
// Optional macro PADDLE_AI_DEADZONE_EN suppresses moves within DEADZONE pixels of the target.
module paddle_ai_ctl #(
   parameter int unsigned STEP_DIV    = 200_000,
   parameter int unsigned RECT_HEIGHT = 100,
   parameter int unsigned Y_LIMIT     = 500,
   parameter int unsigned Y_HOME      = 250,
   parameter int unsigned REACT_X     = 512,
   parameter int unsigned DEADZONE    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [10:0] ball_xpos,
   input  logic [10:0] ball_ypos,
   output logic [10:0] rect_y_pos,
   output logic        moving_up,
   output logic        moving_down
);

   localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned POS_W = 11;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_TRACK  = 2'd1;
   localparam logic [1:0] S_RETURN = 2'd2;

   // DEADZONE is a pixel distance and must fit the coordinate range
   if (DEADZONE >= (1 << POS_W)) begin : g_dz_check
      $error("DEADZONE out of range");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             up_q, up_d;
   logic             down_q, down_d;

   logic               tick_c;
   logic               react_c;
   logic signed [11:0] track_raw_c;
   logic [POS_W-1:0]   track_tgt_c;
   logic [POS_W-1:0]   target_c;
   logic               go_up_c;
   logic               go_down_c;
   logic               move_ok_c;
`ifdef PADDLE_AI_DEADZONE_EN
   logic [POS_W-1:0]   dist_c;
`endif

   always_comb begin
      cnt_d   = cnt_q;
      tick_c  = (cnt_q == CNT_W'(STEP_DIV - 1));
      cnt_d   = tick_c ? '0 : cnt_q + CNT_W'(1);
      react_c = (ball_xpos >= POS_W'(REACT_X));

      // Every active state reduces to the same rule: near ball tracks, far ball returns
      state_d = state_q;
      if (!enable)       state_d = S_IDLE;
      else if (react_c)  state_d = S_TRACK;
      else               state_d = S_RETURN;

      track_raw_c = $signed({1'b0, ball_ypos}) - $signed(12'(RECT_HEIGHT / 2));
      track_tgt_c = '0;
      if (track_raw_c < 12'sd0)                        track_tgt_c = '0;
      else if (track_raw_c > $signed(12'(Y_LIMIT)))    track_tgt_c = POS_W'(Y_LIMIT);
      else                                             track_tgt_c = POS_W'(track_raw_c);

      // A tick coinciding with a state change steers toward the new state's target
      target_c  = (state_d == S_TRACK) ? track_tgt_c : POS_W'(Y_HOME);
      go_up_c   = (target_c < pos_q);
      go_down_c = (target_c > pos_q);

`ifdef PADDLE_AI_DEADZONE_EN
      dist_c    = go_down_c ? (target_c - pos_q) : (pos_q - target_c);
      move_ok_c = (dist_c > POS_W'(DEADZONE));
`else
      move_ok_c = 1'b1;
`endif

      pos_d  = pos_q;
      up_d   = up_q;
      down_d = down_q;
      if (state_d == S_IDLE) begin
         up_d   = 1'b0;
         down_d = 1'b0;
      end else if (tick_c) begin
         up_d   = 1'b0;
         down_d = 1'b0;
         if (move_ok_c && go_down_c) begin
            pos_d  = pos_q + POS_W'(1);
            down_d = 1'b1;
         end else if (move_ok_c && go_up_c) begin
            pos_d  = pos_q - POS_W'(1);
            up_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         state_q <= S_IDLE;
         pos_q   <= POS_W'(Y_HOME);
         up_q    <= 1'b0;
         down_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         pos_q   <= pos_d;
         up_q    <= up_d;
         down_q  <= down_d;
      end
   end

   assign rect_y_pos  = pos_q;
   assign moving_up   = up_q;
   assign moving_down = down_q;

endmodule

// File: doc/paddle_ai_ctl.md
PADDLE_AI_CTL -- requirements
Module: paddle_ai_ctl

Interface
REQ-001 Parameter STEP_DIV, default 200_000: clock cycles per one-pixel paddle step.
REQ-002 Parameter RECT_HEIGHT, default 100: paddle height in pixels.
REQ-003 Parameter Y_LIMIT, default 500: maximum paddle top position in pixels.
REQ-004 Parameter Y_HOME, default 250: idle/return paddle top position.
REQ-005 Parameter REACT_X, default 512: ball x at or beyond which the paddle tracks the ball.
REQ-006 Parameter DEADZONE, default 4: tracking tolerance in pixels, used only with the configuration macro.
REQ-007 clk  input  1  system clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 enable  input  1  game in play; low forces the IDLE state.
REQ-010 ball_xpos  input  11  ball x position from the ball controller.
REQ-011 ball_ypos  input  11  ball y position from the ball controller.
REQ-012 rect_y_pos  output  11  paddle top y position, registered.
REQ-013 moving_up  output  1  high while the paddle is stepping toward smaller y, registered.
REQ-014 moving_down  output  1  high while the paddle is stepping toward larger y, registered.

Function
REQ-015 The step divider shall count 0..STEP_DIV-1, wrap to 0, and assert a one-cycle internal tick at count STEP_DIV-1.
REQ-016 The divider shall run in every state and shall not restart on state changes.
REQ-017 The FSM shall have three states: IDLE, TRACK and RETURN.
REQ-018 IDLE: rect_y_pos holds; next state is TRACK when enable=1 and ball_xpos>=REACT_X; RETURN when enable=1 and ball_xpos<REACT_X.
REQ-019 TRACK: target = ball_ypos - RECT_HEIGHT/2, computed in 12-bit signed arithmetic; a negative result clamps to 0 and a result above Y_LIMIT clamps to Y_LIMIT.
REQ-020 RETURN: target = Y_HOME.
REQ-021 TRACK goes to RETURN when ball_xpos<REACT_X; RETURN goes to TRACK when ball_xpos>=REACT_X; either state goes to IDLE when enable=0, with enable=0 taking priority.
REQ-022 On a tick in TRACK or RETURN, rect_y_pos shall move exactly 1 pixel toward the target; when rect_y_pos equals the target it shall not change.
REQ-023 rect_y_pos shall never leave the range 0..Y_LIMIT, including when a target changes mid-step.
REQ-024 moving_up and moving_down shall be updated on each tick to reflect that tick's move, and shall never both be 1.
REQ-025 moving_up and moving_down shall clear on the first tick with no move, and on entry to IDLE.
REQ-026 The state transition and the position update use values sampled in the same cycle; a tick coinciding with a state change uses the target of the new state.
REQ-027 Ball inputs are treated as quasi-static; no synchronisation is applied inside the block.

Reset
REQ-028 Asserting rst shall immediately set rect_y_pos=Y_HOME, moving_up=0, moving_down=0, divider=0 and state=IDLE, without waiting for a clock edge.
REQ-029 Reset asserted in the middle of a step shall abandon the step; after release the first tick occurs STEP_DIV cycles later.

Configuration
REQ-030 Macro PADDLE_AI_DEADZONE_EN defined: a move shall occur only when |target - rect_y_pos| > DEADZONE.
REQ-031 Macro PADDLE_AI_DEADZONE_EN undefined: a move shall occur whenever target != rect_y_pos, and the DEADZONE parameter is unused.

Verification
REQ-032 Reset with STEP_DIV=4, Y_HOME=250, enable=0 -> rect_y_pos=250 stays constant for 100 cycles, and both move flags stay 0.
REQ-033 STEP_DIV=4, enable=1, ball_xpos=600, ball_ypos=400 -> target=350; rect_y_pos increments by 1 every 4 cycles, moving_down=1, and rect_y_pos reaches 350 after 400 cycles and then holds with moving_down=0.
REQ-034 ball_ypos=10 with rect_y_pos=3 in TRACK -> rect_y_pos reaches 0 and stays at 0; ball_ypos=700 -> rect_y_pos saturates at 500.
REQ-035 In TRACK at rect_y_pos=350, change ball_xpos to 100 -> RETURN; rect_y_pos steps down to 250 with moving_up=1; driving enable=0 mid-return freezes the position and clears the flags.
REQ-036 With PADDLE_AI_DEADZONE_EN defined, target - rect_y_pos = 3 -> no move; = 5 -> a move on the next tick. Without the macro, a difference of 3 -> the paddle moves.
REQ-037 Assert rst asynchronously, between edges, during a TRACK step -> outputs take their reset values immediately; the first step after release occurs exactly STEP_DIV cycles later.
